// File: rtl/serial_add_arb.sv
// Two-requester serial adder: round-robin arbitration picks one operand pair,
// which is then added one bit per cycle, LSB first, through a carry register.
module serial_add_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic             gnt_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
  logic [CW-1:0]    cnt;
  logic             carry, carry_next, s_bit, p_bit, g_bit;
  logic             owner, last, winner, capture, last_bit;

  // On a tie the requester that was not served last wins.
  assign winner   = (req0 && req1) ? ~last : req1;
  assign capture  = (state == IDLE) && (req0 || req1);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    p_bit      = a_sh[0] ^ b_sh[0];
    g_bit      = a_sh[0] & b_sh[0];
    s_bit      = p_bit ^ carry;
    carry_next = g_bit | (p_bit & carry);
  end

  // Each new sum bit enters at the MSB so bit i lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = s_bit;
    end else begin : g_res_wn
      assign res_next = {s_bit, res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = ADD;
      ADD:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      owner  <= 1'b0;
      last   <= 1'b1;
      sum    <= '0;
      cout   <= 1'b0;
      gnt_id <= 1'b0;
    end else begin
      ack0 <= capture && !winner;
      ack1 <= capture && winner;
      if (capture) begin
        a_sh  <= winner ? a1 : a0;
        b_sh  <= winner ? b1 : b0;
        res   <= '0;
        carry <= 1'b0;
        cnt   <= '0;
        owner <= winner;
        last  <= winner;
      end else if (state == ADD) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        res   <= res_next;
        carry <= carry_next;
        cnt   <= cnt + 1'b1;
        if (last_bit) begin
          sum    <= res_next;
          cout   <= carry_next;
          gnt_id <= owner;
        end
      end
    end
  end

endmodule

// File: doc/serial_add_arb.md
SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (WIDTH >= 1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 SHALL have ports a0, b0, a1, b1  input  WIDTH each  operands of requester 0 / 1, held stable while the matching req is high.
REQ-006 SHALL have ports ack0, ack1  output  1 each  one-cycle pulse: operands of that requester captured.
REQ-007 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse: sum, cout, gnt_id valid.
REQ-009 SHALL have port gnt_id  output  1  requester that owns the current sum/cout.
REQ-010 SHALL have ports sum  output  WIDTH  and  cout  output  1  registered result of the addition.

Function
REQ-011 SHALL implement FSM states IDLE, ADD, DONE; transitions: IDLE->ADD on capture, ADD->DONE after the WIDTH-th bit, DONE->IDLE unconditionally.
REQ-012 SHALL capture in IDLE on the rising edge where req0 or req1 is high: load the winner's a/b into internal shift registers, clear carry, clear bit counter, and record winner id.
REQ-013 SHALL arbitrate round-robin: one request -> that requester wins; both -> the requester not served last wins; last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-014 SHALL update the last-served pointer only on capture.
REQ-015 SHALL pulse ack of the winner high for exactly the first ADD cycle; the other ack stays low; requester deasserts req after seeing ack.
REQ-016 SHALL sample req only in IDLE; req changes during ADD/DONE are ignored.
REQ-017 SHALL process one bit per ADD cycle, LSB first, using a half-adder pair: p = a^b, g = a&b, s = p^c, next c = g | (p&c).
REQ-018 SHALL shift each s into the MSB end of an internal result register, so after WIDTH cycles bit i holds result bit i.
REQ-019 SHALL, on the ADD->DONE edge, load sum from the result register, cout from the final carry, and gnt_id from the recorded winner.
REQ-020 SHALL hold sum, cout, and gnt_id stable from that edge until the next ADD->DONE edge.
REQ-021 SHALL assert done high only during the DONE cycle.
REQ-022 SHALL meet these latencies: capture edge at cycle T; ADD occupies T+1..T+WIDTH; done high in cycle T+WIDTH+1; next capture no earlier than the edge ending the following IDLE cycle.
REQ-023 SHALL produce results where {cout,sum} equals a+b modulo 2^(WIDTH+1), i.e. exactly, for all operand values including all-ones.
REQ-024 SHALL, if the loser's req stays high, serve it at the next IDLE capture, so neither requester starves.

Reset
REQ-025 SHALL, while rst is high, force IDLE, and clear ack0, ack1, busy, done, gnt_id, sum, cout, carry, bit counter, and shift registers to 0.
REQ-026 SHALL, while rst is high, set the last-served pointer to 1.
REQ-027 SHALL abort any in-progress operation on rst asserted mid-ADD or mid-DONE, with no done pulse for it; after release the FSM waits in IDLE for a fresh req.

Verification
REQ-028 SHALL cover: req0 alone, a0=8'hFF, b0=8'h01 -> ack0 at T+1; done at T+9; sum=8'h00, cout=1, gnt_id=0.
REQ-029 SHALL cover: req0 and req1 rise together, a0=3, b0=4, a1=10, b1=20, each req held until its ack -> first done: gnt_id=0, sum=7; second done: gnt_id=1, sum=30, cout=0.
REQ-030 SHALL cover: req0 and req1 held high for 4 transactions -> gnt_id sequence 0,1,0,1; exactly one ack per capture; busy low for exactly one cycle between transactions.
REQ-031 SHALL cover: a=8'hAA, b=8'h55 -> sum=8'hFF, cout=0; a=0, b=0 -> sum=0, cout=0; sum/cout unchanged between done pulses.
REQ-032 SHALL cover: rst pulsed at T+4 of a transaction -> all outputs 0 immediately, no done; next tie grants requester 0.
REQ-033 SHALL cover: WIDTH=1, a0=1, b0=1 -> done at T+2, sum=0, cout=1.
